// File: rtl/mem_controller.sv
// ---------------------------------------------------------------------------
// mem_controller
//   Responder end of the LSU memory handshake. Collects read/write requests
//   from NUM_CONSUMERS load/store units, grants one at a time in round-robin
//   order onto a single external data-memory channel, and relays completion
//   (ready, plus read data) back to the granted LSU. Only one memory
//   transaction is ever outstanding.
//
// Ports
//   clk                     in   clock, all state on rising edge
//   reset                   in   synchronous, active-high
//   consumer_read_valid     in   [N]      per-LSU read request
//   consumer_read_address   in   [N*A]    packed, slot i = [i*A +: A]
//   consumer_read_ready     out  [N]      per-LSU read complete
//   consumer_read_data      out  [N*D]    packed read data, slot kept after ready drops
//   consumer_write_valid    in   [N]      per-LSU write request
//   consumer_write_address  in   [N*A]    packed
//   consumer_write_data     in   [N*D]    packed
//   consumer_write_ready    out  [N]      per-LSU write complete
//   mem_read_valid          out           read request to memory
//   mem_read_address        out  [A]
//   mem_read_ready          in            memory read done, mem_read_data valid
//   mem_read_data           in   [D]
//   mem_write_valid         out           write request to memory
//   mem_write_address       out  [A]
//   mem_write_data          out  [D]
//   mem_write_ready         in            memory write done
// ---------------------------------------------------------------------------
module mem_controller #(
    parameter int unsigned NUM_CONSUMERS = 4,
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,

    input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_read_data,

    input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]             consumer_write_ready,

    output logic                                 mem_read_valid,
    output logic [ADDR_BITS-1:0]                 mem_read_address,
    input  logic                                 mem_read_ready,
    input  logic [DATA_BITS-1:0]                 mem_read_data,

    output logic                                 mem_write_valid,
    output logic [ADDR_BITS-1:0]                 mem_write_address,
    output logic [DATA_BITS-1:0]                 mem_write_data,
    input  logic                                 mem_write_ready
);

    localparam int unsigned GRANT_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ_WAIT,
        S_WRITE_WAIT,
        S_READ_RELAY,
        S_WRITE_RELAY
    } state_t;

    // State and registered outputs
    state_t                             r_state;
    logic [GRANT_BITS-1:0]              r_grant;
    logic [GRANT_BITS-1:0]              r_last_grant;
    logic [NUM_CONSUMERS-1:0]           r_cons_rd_ready;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] r_cons_rd_data;
    logic [NUM_CONSUMERS-1:0]           r_cons_wr_ready;
    logic                               r_mem_rd_valid;
    logic [ADDR_BITS-1:0]               r_mem_rd_addr;
    logic                               r_mem_wr_valid;
    logic [ADDR_BITS-1:0]               r_mem_wr_addr;
    logic [DATA_BITS-1:0]               r_mem_wr_data;

    // Next-state values
    state_t                             w_nxt_state;
    logic [GRANT_BITS-1:0]              w_nxt_grant;
    logic [GRANT_BITS-1:0]              w_nxt_last_grant;
    logic [NUM_CONSUMERS-1:0]           w_nxt_cons_rd_ready;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] w_nxt_cons_rd_data;
    logic [NUM_CONSUMERS-1:0]           w_nxt_cons_wr_ready;
    logic                               w_nxt_mem_rd_valid;
    logic [ADDR_BITS-1:0]               w_nxt_mem_rd_addr;
    logic                               w_nxt_mem_wr_valid;
    logic [ADDR_BITS-1:0]               w_nxt_mem_wr_addr;
    logic [DATA_BITS-1:0]               w_nxt_mem_wr_data;

    // Arbitration results
    logic [NUM_CONSUMERS-1:0]           w_req_any;
    logic                               w_req_found;
    logic [GRANT_BITS-1:0]              w_req_sel;
    logic [ADDR_BITS-1:0]               w_sel_rd_addr;
    logic [ADDR_BITS-1:0]               w_sel_wr_addr;
    logic [DATA_BITS-1:0]               w_sel_wr_data;

    assign w_req_any = consumer_read_valid | consumer_write_valid;

    // Round-robin scan starting just after the most recent grant
    always_comb begin : arbiter
        int unsigned idx;
        idx         = 0;
        w_req_found = 1'b0;
        w_req_sel   = '0;
        for (int unsigned k = 1; k <= NUM_CONSUMERS; k++) begin
            idx = 32'(r_last_grant) + k;
            if (idx >= NUM_CONSUMERS) begin
                idx = idx - NUM_CONSUMERS;
            end
            if (!w_req_found && w_req_any[GRANT_BITS'(idx)]) begin
                w_req_found = 1'b1;
                w_req_sel   = GRANT_BITS'(idx);
            end
        end
    end

    // Payload of the consumer about to be granted
    assign w_sel_rd_addr = consumer_read_address[32'(w_req_sel)*ADDR_BITS +: ADDR_BITS];
    assign w_sel_wr_addr = consumer_write_address[32'(w_req_sel)*ADDR_BITS +: ADDR_BITS];
    assign w_sel_wr_data = consumer_write_data[32'(w_req_sel)*DATA_BITS +: DATA_BITS];

    // Next-state and next-output logic
    always_comb begin : next_state
        w_nxt_state         = r_state;
        w_nxt_grant         = r_grant;
        w_nxt_last_grant    = r_last_grant;
        w_nxt_cons_rd_ready = r_cons_rd_ready;
        w_nxt_cons_rd_data  = r_cons_rd_data;
        w_nxt_cons_wr_ready = r_cons_wr_ready;
        w_nxt_mem_rd_valid  = r_mem_rd_valid;
        w_nxt_mem_rd_addr   = r_mem_rd_addr;
        w_nxt_mem_wr_valid  = r_mem_wr_valid;
        w_nxt_mem_wr_addr   = r_mem_wr_addr;
        w_nxt_mem_wr_data   = r_mem_wr_data;

        case (r_state)
            S_IDLE: begin
                if (w_req_found) begin
                    w_nxt_grant      = w_req_sel;
                    w_nxt_last_grant = w_req_sel;
                    // A consumer with both requests pending is served read first
                    if (consumer_read_valid[w_req_sel]) begin
                        w_nxt_mem_rd_valid = 1'b1;
                        w_nxt_mem_rd_addr  = w_sel_rd_addr;
                        w_nxt_state        = S_READ_WAIT;
                    end else begin
                        w_nxt_mem_wr_valid = 1'b1;
                        w_nxt_mem_wr_addr  = w_sel_wr_addr;
                        w_nxt_mem_wr_data  = w_sel_wr_data;
                        w_nxt_state        = S_WRITE_WAIT;
                    end
                end
            end

            S_READ_WAIT: begin
                // Completes even if the consumer withdrew its request meanwhile
                if (mem_read_ready) begin
                    w_nxt_mem_rd_valid                                      = 1'b0;
                    w_nxt_cons_rd_ready[r_grant]                            = 1'b1;
                    w_nxt_cons_rd_data[32'(r_grant)*DATA_BITS +: DATA_BITS] = mem_read_data;
                    w_nxt_state                                             = S_READ_RELAY;
                end
            end

            S_WRITE_WAIT: begin
                if (mem_write_ready) begin
                    w_nxt_mem_wr_valid           = 1'b0;
                    w_nxt_cons_wr_ready[r_grant] = 1'b1;
                    w_nxt_state                  = S_WRITE_RELAY;
                end
            end

            S_READ_RELAY: begin
                // Ready held until the consumer acknowledges by dropping valid
                if (!consumer_read_valid[r_grant]) begin
                    w_nxt_cons_rd_ready = '0;
                    w_nxt_state         = S_IDLE;
                end
            end

            S_WRITE_RELAY: begin
                if (!consumer_write_valid[r_grant]) begin
                    w_nxt_cons_wr_ready = '0;
                    w_nxt_state         = S_IDLE;
                end
            end

            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    // State register; reset abandons any in-flight memory operation
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_grant         <= '0;
            r_last_grant    <= GRANT_BITS'(NUM_CONSUMERS - 1);
            r_cons_rd_ready <= '0;
            r_cons_rd_data  <= '0;
            r_cons_wr_ready <= '0;
            r_mem_rd_valid  <= 1'b0;
            r_mem_rd_addr   <= '0;
            r_mem_wr_valid  <= 1'b0;
            r_mem_wr_addr   <= '0;
            r_mem_wr_data   <= '0;
        end else begin
            r_state         <= w_nxt_state;
            r_grant         <= w_nxt_grant;
            r_last_grant    <= w_nxt_last_grant;
            r_cons_rd_ready <= w_nxt_cons_rd_ready;
            r_cons_rd_data  <= w_nxt_cons_rd_data;
            r_cons_wr_ready <= w_nxt_cons_wr_ready;
            r_mem_rd_valid  <= w_nxt_mem_rd_valid;
            r_mem_rd_addr   <= w_nxt_mem_rd_addr;
            r_mem_wr_valid  <= w_nxt_mem_wr_valid;
            r_mem_wr_addr   <= w_nxt_mem_wr_addr;
            r_mem_wr_data   <= w_nxt_mem_wr_data;
        end
    end

    assign consumer_read_ready  = r_cons_rd_ready;
    assign consumer_read_data   = r_cons_rd_data;
    assign consumer_write_ready = r_cons_wr_ready;
    assign mem_read_valid       = r_mem_rd_valid;
    assign mem_read_address     = r_mem_rd_addr;
    assign mem_write_valid      = r_mem_wr_valid;
    assign mem_write_address    = r_mem_wr_addr;
    assign mem_write_data       = r_mem_wr_data;

endmodule

// File: tb/tb_mem_controller.sv
// ---------------------------------------------------------------------------
// tb_mem_controller
//   Directed bench for mem_controller. The driver issues LSU requests and
//   pushes the expected memory-request / consumer-ready events into a queue;
//   a negedge monitor pops and compares whenever the DUT raises a valid or
//   ready. A simple memory responder and consumer release logic run inside
//   the per-cycle tick of the driver.
// ---------------------------------------------------------------------------
module tb_mem_controller;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      rv;
    logic [N*AW-1:0]   ra;
    logic [N-1:0]      consumer_read_ready;
    logic [N*DW-1:0]   consumer_read_data;
    logic [N-1:0]      wv;
    logic [N*AW-1:0]   wa;
    logic [N*DW-1:0]   wd;
    logic [N-1:0]      consumer_write_ready;
    logic              mem_read_valid;
    logic [AW-1:0]     mem_read_address;
    logic              mrr;
    logic [DW-1:0]     mrd;
    logic              mem_write_valid;
    logic [AW-1:0]     mem_write_address;
    logic [DW-1:0]     mem_write_data;
    logic              mwr;

    mem_controller #(
        .NUM_CONSUMERS (N),
        .ADDR_BITS     (AW),
        .DATA_BITS     (DW)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (rv),
        .consumer_read_address  (ra),
        .consumer_read_ready    (consumer_read_ready),
        .consumer_read_data     (consumer_read_data),
        .consumer_write_valid   (wv),
        .consumer_write_address (wa),
        .consumer_write_data    (wd),
        .consumer_write_ready   (consumer_write_ready),
        .mem_read_valid         (mem_read_valid),
        .mem_read_address       (mem_read_address),
        .mem_read_ready         (mrr),
        .mem_read_data          (mrd),
        .mem_write_valid        (mem_write_valid),
        .mem_write_address      (mem_write_address),
        .mem_write_data         (mem_write_data),
        .mem_write_ready        (mwr)
    );

    always #5 clk = ~clk;

    typedef enum logic [1:0] {EV_MRD, EV_MWR, EV_CRD, EV_CWR} ev_kind_t;
    typedef struct packed {
        ev_kind_t    kind;
        logic [1:0]  idx;
        logic [7:0]  addr;
        logic [7:0]  data;
    } ev_t;

    ev_t        exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] mem_arr [256];
    bit         mem_auto;
    bit         auto_rel;
    int         mem_lat;
    int         mcnt;
    bit         mon_en = 1'b0;

    logic         prev_mrv = 1'b0;
    logic         prev_mwv = 1'b0;
    logic [N-1:0] prev_crr = '0;
    logic [N-1:0] prev_cwr = '0;

    function automatic ev_t mk(ev_kind_t k, int i, logic [7:0] a, logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.idx  = 2'(i);
        e.addr = a;
        e.data = d;
        return e;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic observe(ev_t o);
        ev_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected: got kind=%0d idx=%0d addr=%h data=%h, expected nothing",
                     o.kind, o.idx, o.addr, o.data);
        end else begin
            e = exp_q.pop_front();
            if (e !== o) begin
                n_err++;
                $display("FAIL sb_event: got kind=%0d idx=%0d addr=%h data=%h, expected kind=%0d idx=%0d addr=%h data=%h",
                         o.kind, o.idx, o.addr, o.data, e.kind, e.idx, e.addr, e.data);
            end
        end
    endtask

    // Monitor: every rising valid/ready is compared against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (mem_read_valid && !prev_mrv)
                    observe(mk(EV_MRD, 0, mem_read_address, 8'h00));
                if (mem_write_valid && !prev_mwv)
                    observe(mk(EV_MWR, 0, mem_write_address, mem_write_data));
                for (int i = 0; i < N; i++) begin
                    if (consumer_read_ready[i] && !prev_crr[i])
                        observe(mk(EV_CRD, i, 8'h00, consumer_read_data[i*DW +: DW]));
                    if (consumer_write_ready[i] && !prev_cwr[i])
                        observe(mk(EV_CWR, i, 8'h00, 8'h00));
                end
            end
            prev_mrv = mem_read_valid;
            prev_mwv = mem_write_valid;
            prev_crr = consumer_read_ready;
            prev_cwr = consumer_write_ready;
        end
    end

    // One clock: memory responder and consumer release act just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        mrr = 1'b0;
        mwr = 1'b0;
        if (mem_auto) begin
            if (mem_read_valid || mem_write_valid) begin
                if (mcnt >= mem_lat) begin
                    if (mem_read_valid) begin
                        mrr = 1'b1;
                        mrd = mem_arr[mem_read_address];
                    end else begin
                        mwr = 1'b1;
                        mem_arr[mem_write_address] = mem_write_data;
                    end
                    mcnt = 0;
                end else begin
                    mcnt++;
                end
            end else begin
                mcnt = 0;
            end
        end
        if (auto_rel) begin
            for (int i = 0; i < N; i++) begin
                if (consumer_read_ready[i])  rv[i] = 1'b0;
                if (consumer_write_ready[i]) wv[i] = 1'b0;
            end
        end
    endtask

    task automatic drain(string name);
        int c;
        c = 0;
        while (!(rv == '0 && wv == '0 && consumer_read_ready == '0 && consumer_write_ready == '0
                 && !mem_read_valid && !mem_write_valid) && c < 200) begin
            tick();
            c++;
        end
        check({name, "_drain"}, 64'(c < 200), 64'd1);
    endtask

    task automatic check_all_zero(string name);
        check({name, "_ctrl"}, 64'({consumer_read_ready, consumer_write_ready, mem_read_valid, mem_write_valid}), 64'd0);
        check({name, "_rdata"}, 64'({consumer_read_data, mem_read_address}), 64'd0);
        check({name, "_wpath"}, 64'({mem_write_address, mem_write_data}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        reset = 1'b1;
        rv = '0; ra = '0; wv = '0; wa = '0; wd = '0;
        mrr = 1'b0; mrd = '0; mwr = 1'b0;
        mem_auto = 1'b1; auto_rel = 1'b1; mem_lat = 0; mcnt = 0;
        for (int i = 0; i < 256; i++) mem_arr[i] = 8'h00;
        mem_arr[8'h3C] = 8'hA5;
        mem_arr[8'h40] = 8'h11; mem_arr[8'h41] = 8'h22;
        mem_arr[8'h42] = 8'h33; mem_arr[8'h43] = 8'h44;
        mem_arr[8'h50] = 8'h55; mem_arr[8'h21] = 8'h6B;
        mem_arr[8'h07] = 8'h5A; mem_arr[8'h60] = 8'hC3;
        mem_arr[8'h61] = 8'h3C;

        tick();
        tick();
        check_all_zero("reset");
        reset  = 1'b0;
        mon_en = 1'b1;

        // Single read, consumer 2
        mem_lat = 3;
        rv[2] = 1'b1; ra[2*AW +: AW] = 8'h3C;
        exp_q.push_back(mk(EV_MRD, 0, 8'h3C, 8'h00));
        exp_q.push_back(mk(EV_CRD, 2, 8'h00, 8'hA5));
        tick();
        check("t1_rd_latency", 64'({mem_read_valid, mem_read_address}), 64'({1'b1, 8'h3C}));
        c = 0;
        while (!mrr && c < 50) begin tick(); c++; end
        check("t1_mem_ready_seen", 64'(mrr), 64'd1);
        check("t1_no_early_ready", 64'(consumer_read_ready), 64'd0);
        tick();
        check("t1_rd_ready", 64'({consumer_read_ready, consumer_read_data[2*DW +: DW]}), 64'({4'b0100, 8'hA5}));
        check("t1_mem_valid_low", 64'(mem_read_valid), 64'd0);
        tick();
        check("t1_ready_drop", 64'(consumer_read_ready), 64'd0);
        check("t1_data_retained", 64'(consumer_read_data[2*DW +: DW]), 64'hA5);
        drain("t1");

        // Single write, consumer 0, valid held by hand
        auto_rel = 1'b0;
        mem_lat  = 1;
        wv[0] = 1'b1; wa[0 +: AW] = 8'h10; wd[0 +: DW] = 8'h7E;
        exp_q.push_back(mk(EV_MWR, 0, 8'h10, 8'h7E));
        exp_q.push_back(mk(EV_CWR, 0, 8'h00, 8'h00));
        tick();
        check("t2_wr_req", 64'({mem_write_valid, mem_read_valid, mem_write_address, mem_write_data}),
              64'({1'b1, 1'b0, 8'h10, 8'h7E}));
        c = 0;
        while (!consumer_write_ready[0] && c < 50) begin tick(); c++; end
        check("t2_wr_ready", 64'(consumer_write_ready), 64'b0001);
        repeat (3) tick();
        check("t2_wr_ready_held", 64'(consumer_write_ready), 64'b0001);
        wv[0] = 1'b0;
        tick();
        check("t2_wr_ready_drop", 64'(consumer_write_ready), 64'd0);
        drain("t2");
        auto_rel = 1'b1;

        // Round robin from reset: 0,1,2,3 then 0 again
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mem_lat = 2;
        for (int i = 0; i < N; i++) ra[i*AW +: AW] = 8'(8'h40 + i);
        rv = 4'hF;
        exp_q.push_back(mk(EV_MRD, 0, 8'h40, 8'h00));
        exp_q.push_back(mk(EV_CRD, 0, 8'h00, 8'h11));
        exp_q.push_back(mk(EV_MRD, 0, 8'h41, 8'h00));
        exp_q.push_back(mk(EV_CRD, 1, 8'h00, 8'h22));
        exp_q.push_back(mk(EV_MRD, 0, 8'h42, 8'h00));
        exp_q.push_back(mk(EV_CRD, 2, 8'h00, 8'h33));
        exp_q.push_back(mk(EV_MRD, 0, 8'h43, 8'h00));
        exp_q.push_back(mk(EV_CRD, 3, 8'h00, 8'h44));
        exp_q.push_back(mk(EV_MRD, 0, 8'h50, 8'h00));
        exp_q.push_back(mk(EV_CRD, 0, 8'h00, 8'h55));
        c = 0;
        while (!consumer_read_ready[0] && c < 50) begin tick(); c++; end
        check("t3_first_grant_c0", 64'(consumer_read_ready), 64'b0001);
        tick();
        tick();
        rv[0] = 1'b1; ra[0 +: AW] = 8'h50;
        drain("t3");

        // Same consumer read + write: read goes first
        mem_lat = 0;
        rv[1] = 1'b1; ra[1*AW +: AW] = 8'h21;
        wv[1] = 1'b1; wa[1*AW +: AW] = 8'h22; wd[1*DW +: DW] = 8'h9C;
        exp_q.push_back(mk(EV_MRD, 0, 8'h21, 8'h00));
        exp_q.push_back(mk(EV_CRD, 1, 8'h00, 8'h6B));
        exp_q.push_back(mk(EV_MWR, 0, 8'h22, 8'h9C));
        exp_q.push_back(mk(EV_CWR, 1, 8'h00, 8'h00));
        tick();
        check("t4_read_first", 64'({mem_read_valid, mem_write_valid, mem_read_address}), 64'({1'b1, 1'b0, 8'h21}));
        drain("t4");

        // Spurious memory readies in IDLE are ignored
        mem_auto = 1'b0;
        mrr = 1'b1; mrd = 8'hEE; mwr = 1'b1;
        tick();
        tick();
        check("t5_no_ready", 64'({consumer_read_ready, consumer_write_ready, mem_read_valid, mem_write_valid}), 64'd0);
        check("t5_data_untouched", 64'(consumer_read_data), 64'h44336B55);
        rv[3] = 1'b1; ra[3*AW +: AW] = 8'h07;
        exp_q.push_back(mk(EV_MRD, 0, 8'h07, 8'h00));
        exp_q.push_back(mk(EV_CRD, 3, 8'h00, 8'h5A));
        tick();
        check("t5_idle_then_read", 64'({mem_read_valid, mem_read_address}), 64'({1'b1, 8'h07}));
        mem_auto = 1'b1;
        drain("t5");

        // Reset while waiting on memory
        mem_auto = 1'b0;
        rv[2] = 1'b1; ra[2*AW +: AW] = 8'h33;
        exp_q.push_back(mk(EV_MRD, 0, 8'h33, 8'h00));
        tick();
        check("t6_in_read_wait", 64'(mem_read_valid), 64'd1);
        tick();
        tick();
        reset = 1'b1;
        rv = '0;
        tick();
        check_all_zero("t6_reset");
        reset = 1'b0;
        rv = 4'b1001;
        ra[0 +: AW] = 8'h60; ra[3*AW +: AW] = 8'h61;
        exp_q.push_back(mk(EV_MRD, 0, 8'h60, 8'h00));
        exp_q.push_back(mk(EV_CRD, 0, 8'h00, 8'hC3));
        exp_q.push_back(mk(EV_MRD, 0, 8'h61, 8'h00));
        exp_q.push_back(mk(EV_CRD, 3, 8'h00, 8'h3C));
        mem_auto = 1'b1;
        mcnt = 0;
        tick();
        check("t6_first_after_reset", 64'({mem_read_valid, mem_read_address}), 64'({1'b1, 8'h60}));
        drain("t6");

        repeat (3) tick();
        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
